// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// Holds the occupancy state encoding and the default counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_CNT_W = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: increments on inc_i, sticks at all-ones.
// Ports: clk_i, rst_n_i (async active-low), inc_i, cnt_o.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and global stall. Ports: clk_i, rst_n_i, stall_i,
// flush_i, in_valid_i/in_ready_o/in_data_i, out_valid_o/out_ready_i/
// out_data_o; stall_cnt_o/flush_cnt_o only when PIPE_STAGE_PERF_EN is
// defined (counter ports and logic vanish otherwise).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    // Ready is a function of registered state only, so no
    // combinational path from out_ready_i back upstream.
    assign in_ready_o  = (state_q != TWO) && !stall_i;
    assign out_valid_o = (state_q != EMPTY) && !stall_i;
    assign out_data_o  = main_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (!stall_i) begin
            if (flush_i) begin
                // Flush wins over a same-cycle accept: data dropped.
                state_d = EMPTY;
                main_d  = FLUSH_VAL;
                skid_d  = FLUSH_VAL;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_d  = in_data_i;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_d = in_data_i;
                        end else if (in_fire) begin
                            skid_d  = in_data_i;
                            state_d = TWO;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VAL;
            skid_q  <= FLUSH_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic flush_hit;

    // Only flushes that actually kill a held entry are counted.
    assign flush_hit = !stall_i && flush_i && (state_q != EMPTY);

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_i),
        .cnt_o   (stall_cnt_o)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (flush_hit),
        .cnt_o   (flush_cnt_o)
    );
`else
    // Performance counters absent; handshake logic is unchanged.
`endif

endmodule
